// File: rtl/riscv_mem_pkg.sv
// Purpose: shared encodings for the load/store path (func3, store type, FSM state, bus widths).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_mem_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;
  localparam int BUS_BW = BUS_DW / 8;

  // Load func3 encodings.
  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  // Store type encodings. The low two bits of a load func3 use the same
  // size code, so these double as the access-size code for both ops.
  localparam logic [1:0] ST_SB  = 2'b00;
  localparam logic [1:0] ST_SH  = 2'b01;
  localparam logic [1:0] ST_SW  = 2'b10;
  localparam logic [1:0] ST_OFF = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_R,
    S_RESP
  } mau_state_t;

  function automatic logic ld_type_legal(input logic [2:0] f3);
    return (f3 == LD_LB) || (f3 == LD_LH) || (f3 == LD_LW) ||
           (f3 == LD_LBU) || (f3 == LD_LHU);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Purpose: extract and extend a load result from a bus word.
// Latency: combinational.
// Backpressure: none.
// Ports: bus_rdata (raw word), offset (byte address [1:0]), func3 (load type) -> ld_data.
module mem_load_align
  import riscv_mem_pkg::*;
(
  input  logic [BUS_DW-1:0] bus_rdata,
  input  logic [1:0]        offset,
  input  logic [2:0]        func3,
  output logic [BUS_DW-1:0] ld_data
);

  logic [BUS_DW-1:0] shifted;

  always_comb begin
    shifted = bus_rdata >> {offset, 3'b000};
    case (func3)
      LD_LB:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
      LD_LH:   ld_data = {{16{shifted[15]}}, shifted[15:0]};
      LD_LBU:  ld_data = {24'b0, shifted[7:0]};
      LD_LHU:  ld_data = {16'b0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Purpose: pipeline load/store unit driving a single-outstanding ready/rvalid memory bus.
// Latency: store 2 stalled cycles, load 3 plus slave response delay; abort after TIMEOUT_CYCLES.
// Backpressure: holds the stage via stall while bus_ready or bus_rvalid is outstanding.
// Ports: clk, rst (async active-low); req_load/req_store/mem_load_type/mem_store_type/addr/wdata
//        from the stage; stall/rdata_valid/rdata/err back to it; bus_* to the memory slave.
module mem_access_unit
  import riscv_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [2:0]        mem_load_type,
  input  logic [1:0]        mem_store_type,
  input  logic [BUS_AW-1:0] addr,
  input  logic [BUS_DW-1:0] wdata,
  output logic              stall,
  output logic              rdata_valid,
  output logic [BUS_DW-1:0] rdata,
  output logic              err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [BUS_AW-1:0] bus_addr,
  output logic [BUS_BW-1:0] bus_be,
  output logic [BUS_DW-1:0] bus_wdata,
  input  logic              bus_ready,
  input  logic              bus_rvalid,
  input  logic [BUS_DW-1:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // Counter reads 0 in the first REQ cycle, so the abort fires in the
  // TIMEOUT_CYCLES-th waiting cycle.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  mau_state_t        state_q, state_d;
  logic              op_load_q;
  logic [2:0]        func3_q;
  logic [1:0]        off_q;
  logic [BUS_AW-1:0] addr_q;
  logic [BUS_BW-1:0] be_q;
  logic [BUS_DW-1:0] wdata_q;
  logic [CW-1:0]     cnt_q;
  logic [BUS_DW-1:0] rdata_q;
  logic              err_q;

  logic [1:0]        size;
  logic              is_req, type_ok, aligned, go, bad, timeout_hit;
  logic [BUS_BW-1:0] be_d;
  logic [BUS_DW-1:0] wdata_d;
  logic [BUS_DW-1:0] ld_data;

  // Request decode; a load wins over a simultaneous store.
  always_comb begin
    size    = req_load ? mem_load_type[1:0] : mem_store_type;
    is_req  = req_load || (req_store && (mem_store_type != ST_OFF));
    type_ok = !req_load || ld_type_legal(mem_load_type);
    case (size)
      ST_SB:   aligned = 1'b1;
      ST_SH:   aligned = !addr[0];
      ST_SW:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    go  = is_req && type_ok && aligned;
    bad = is_req && !go;
    case (size)
      ST_SB: begin
        be_d    = 4'b0001 << addr[1:0];
        wdata_d = {4{wdata[7:0]}};
      end
      ST_SH: begin
        be_d    = 4'b0011 << {addr[1], 1'b0};
        wdata_d = {2{wdata[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = wdata;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    stall       = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Gated by rst so the stage is not held while the unit sits in reset.
        stall = go && rst;
        if (go) state_d = S_REQ;
      end
      S_REQ: begin
        stall = 1'b1;
        if (bus_ready) begin
          state_d = op_load_q ? S_WAIT_R : S_RESP;
        end else if (cnt_q >= CNT_LAST) begin
          timeout_hit = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_WAIT_R: begin
        stall = 1'b1;
        if (bus_rvalid) begin
          state_d = S_RESP;
        end else if (cnt_q >= CNT_LAST) begin
          timeout_hit = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      op_load_q <= 1'b0;
      func3_q   <= 3'b000;
      off_q     <= 2'b00;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go) begin
            op_load_q <= req_load;
            func3_q   <= mem_load_type;
            off_q     <= addr[1:0];
            addr_q    <= {addr[BUS_AW-1:2], 2'b00};
            be_q      <= be_d;
            wdata_q   <= req_load ? '0 : wdata_d;
            cnt_q     <= '0;
          end else if (bad) begin
            err_q <= 1'b1;
          end
        end
        S_REQ, S_WAIT_R: begin
          cnt_q <= cnt_q + CW'(1);
          if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else if ((state_q == S_WAIT_R) && bus_rvalid) begin
            rdata_q <= ld_data;
          end
        end
        default: ;
      endcase
    end
  end

  mem_load_align u_align (
    .bus_rdata (bus_rdata),
    .offset    (off_q),
    .func3     (func3_q),
    .ld_data   (ld_data)
  );

  assign bus_req     = (state_q == S_REQ);
  assign bus_we      = bus_req && !op_load_q;
  assign bus_addr    = addr_q;
  assign bus_be      = be_q;
  assign bus_wdata   = wdata_q;
  assign rdata_valid = (state_q == S_RESP) && op_load_q;
  assign rdata       = rdata_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Purpose: directed self-checking bench for mem_access_unit with a load-result scoreboard.
// Latency: n/a.
// Backpressure: bus_ready/bus_rvalid driven directly by the stimulus.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_load, req_store;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_store_type;
  logic [31:0] addr, wdata;
  logic        stall, rdata_valid, err;
  logic [31:0] rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready, bus_rvalid;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_load       (req_load),
    .req_store      (req_store),
    .mem_load_type  (mem_load_type),
    .mem_store_type (mem_store_type),
    .addr           (addr),
    .wdata          (wdata),
    .stall          (stall),
    .rdata_valid    (rdata_valid),
    .rdata          (rdata),
    .err            (err),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_be         (bus_be),
    .bus_wdata      (bus_wdata),
    .bus_ready      (bus_ready),
    .bus_rvalid     (bus_rvalid),
    .bus_rdata      (bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard: every rdata_valid pulse must match the oldest pushed load result.
  always @(negedge clk) begin
    if (rdata_valid === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_rdata_valid observed=1 expected=0");
      end
      if (exp_q.size() > 0) chk("rdata", rdata, exp_q.pop_front());
    end
  end

  task automatic do_store(input string tag, input logic [1:0] st, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd);
    cyc();
    req_store = 1'b1; mem_store_type = st; addr = a; wdata = wd;
    smp();
    chk({tag, "_idle_stall"}, 32'(stall), 32'd1);
    chk({tag, "_idle_bus_req"}, 32'(bus_req), 32'd0);
    cyc();
    req_store = 1'b0;
    smp();
    chk({tag, "_bus_req"}, 32'(bus_req), 32'd1);
    chk({tag, "_bus_we"}, 32'(bus_we), 32'd1);
    chk({tag, "_bus_be"}, 32'(bus_be), 32'(exp_be));
    chk({tag, "_bus_addr"}, bus_addr, {a[31:2], 2'b00});
    chk({tag, "_bus_wdata"}, bus_wdata, exp_wd);
    chk({tag, "_req_stall"}, 32'(stall), 32'd1);
    cyc();
    smp();
    chk({tag, "_resp_stall"}, 32'(stall), 32'd0);
    chk({tag, "_resp_err"}, 32'(err), 32'd0);
    chk({tag, "_resp_bus_req"}, 32'(bus_req), 32'd0);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rd, input logic [31:0] exp, input logic with_store);
    cyc();
    req_load = 1'b1; mem_load_type = f3; addr = a;
    req_store = with_store; mem_store_type = 2'b10; wdata = 32'h5555_AAAA;
    exp_q.push_back(exp);
    smp();
    chk({tag, "_idle_stall"}, 32'(stall), 32'd1);
    cyc();
    req_load = 1'b0; req_store = 1'b0;
    // Response during the acceptance cycle must be ignored.
    bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    smp();
    chk({tag, "_bus_req"}, 32'(bus_req), 32'd1);
    chk({tag, "_bus_we"}, 32'(bus_we), 32'd0);
    chk({tag, "_bus_addr"}, bus_addr, {a[31:2], 2'b00});
    cyc();
    bus_rvalid = 1'b0;
    smp();
    chk({tag, "_wait_bus_req"}, 32'(bus_req), 32'd0);
    chk({tag, "_wait_stall"}, 32'(stall), 32'd1);
    cyc();
    bus_rvalid = 1'b1; bus_rdata = rd;
    smp();
    chk({tag, "_wait2_stall"}, 32'(stall), 32'd1);
    cyc();
    bus_rvalid = 1'b0; bus_rdata = 32'h0;
    smp();
    chk({tag, "_resp_stall"}, 32'(stall), 32'd0);
    chk({tag, "_resp_valid"}, 32'(rdata_valid), 32'd1);
    chk({tag, "_resp_err"}, 32'(err), 32'd0);
  endtask

  task automatic err_case(input string tag, input logic ld, input logic [2:0] f3,
                          input logic [1:0] st, input logic [31:0] a, input logic exp_err);
    cyc();
    req_load = ld; req_store = !ld; mem_load_type = f3; mem_store_type = st; addr = a;
    smp();
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_bus_req"}, 32'(bus_req), 32'd0);
    cyc();
    req_load = 1'b0; req_store = 1'b0;
    smp();
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_no_bus_req"}, 32'(bus_req), 32'd0);
    cyc();
    smp();
    chk({tag, "_err_clear"}, 32'(err), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    req_load = 1'b1; req_store = 1'b0;   // request held during reset: must not stall
    mem_load_type = 3'b010; mem_store_type = 2'b00;
    addr = 32'h0; wdata = 32'h0;
    bus_ready = 1'b1; bus_rvalid = 1'b0; bus_rdata = 32'h0;

    repeat (2) smp();
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_bus_be", 32'(bus_be), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    req_load = 1'b0;
    rst = 1'b1;

    do_store("sw", 2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    do_store("sb", 2'b00, 32'h0000_0103, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
    do_store("sh", 2'b01, 32'h0000_0102, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF);

    do_load("lb", 3'b000, 32'h0000_0202, 32'h12F0_3456, 32'hFFFF_FFF0, 1'b0);
    do_load("lbu", 3'b100, 32'h0000_0202, 32'h12F0_3456, 32'h0000_00F0, 1'b0);
    do_load("lh", 3'b001, 32'h0000_0302, 32'h8001_1234, 32'hFFFF_8001, 1'b0);
    do_load("lhu", 3'b101, 32'h0000_0300, 32'h0000_9ABC, 32'h0000_9ABC, 1'b0);
    do_load("lw_vs_sw", 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1);

    err_case("lh_mis", 1'b1, 3'b001, 2'b00, 32'h0000_0301, 1'b1);
    err_case("lw_mis", 1'b1, 3'b010, 2'b00, 32'h0000_0302, 1'b1);
    err_case("ld_f3_011", 1'b1, 3'b011, 2'b00, 32'h0000_0000, 1'b1);
    err_case("sh_mis", 1'b0, 3'b000, 2'b01, 32'h0000_0201, 1'b1);
    err_case("st_off", 1'b0, 3'b000, 2'b11, 32'h0000_0200, 1'b0);

    // Timeout: slave never accepts.
    cyc();
    bus_ready = 1'b0;
    req_load = 1'b1; mem_load_type = 3'b010; addr = 32'h0000_0500;
    exp_q.push_back(32'h0);
    smp();
    chk("to_idle_stall", 32'(stall), 32'd1);
    cyc();
    req_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("to_req_bus_req", 32'(bus_req), 32'd1);
      chk("to_req_err", 32'(err), 32'd0);
      cyc();
    end
    smp();
    chk("to_resp_err", 32'(err), 32'd1);
    chk("to_resp_stall", 32'(stall), 32'd0);
    chk("to_resp_valid", 32'(rdata_valid), 32'd1);
    cyc();
    smp();
    chk("to_idle_err", 32'(err), 32'd0);
    chk("to_idle_bus_req", 32'(bus_req), 32'd0);
    bus_ready = 1'b1;

    // Reset while waiting for the read response.
    cyc();
    req_load = 1'b1; mem_load_type = 3'b010; addr = 32'h0000_0600;
    cyc();
    req_load = 1'b0;
    cyc();
    smp();
    chk("rw_wait_stall", 32'(stall), 32'd1);
    cyc();
    #1 rst = 1'b0;
    #1;
    chk("rw_rst_stall", 32'(stall), 32'd0);
    chk("rw_rst_bus_req", 32'(bus_req), 32'd0);
    smp();
    rst = 1'b1;
    cyc();
    bus_rvalid = 1'b1; bus_rdata = 32'h1111_2222;
    cyc();
    bus_rvalid = 1'b0;
    repeat (3) cyc();
    smp();
    chk("rw_late_rvalid", 32'(rdata_valid), 32'd0);

    // Reset while the request is on the bus: bus_req must drop without a clock edge.
    cyc();
    bus_ready = 1'b0;
    req_load = 1'b1; mem_load_type = 3'b010; addr = 32'h0000_0700;
    cyc();
    req_load = 1'b0;
    #1;
    chk("rq_bus_req", 32'(bus_req), 32'd1);
    rst = 1'b0;
    #1;
    chk("rq_rst_bus_req", 32'(bus_req), 32'd0);
    chk("rq_rst_bus_addr", bus_addr, 32'd0);
    smp();
    rst = 1'b1;
    bus_ready = 1'b1;

    do_store("sw_after_rst", 2'b10, 32'h0000_0104, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D);

    repeat (2) cyc();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001: Parameter TIMEOUT_CYCLES, default 255: bus wait cycles before abort.
REQ-002: clk  in  1  single clock; all state updates on rising edge.
REQ-003: rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-004: req_load  in  1  load instruction present in the stage.
REQ-005: req_store  in  1  store instruction present in the stage.
REQ-006: mem_load_type  in  3  func3 of the load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-007: mem_store_type  in  2  00 SB, 01 SH, 10 SW, 11 disabled.
REQ-008: addr  in  32  effective byte address.
REQ-009: wdata  in  32  store data, right-aligned.
REQ-010: stall  out  1  hold the pipeline stage.
REQ-011: rdata_valid  out  1  one-cycle pulse; load result on rdata.
REQ-012: rdata  out  32  extended load result.
REQ-013: err  out  1  one-cycle pulse: misaligned, illegal type or timeout.
REQ-014: bus_req, bus_we  out  1 each  request, write enable.
REQ-015: bus_addr  out  32  word-aligned address {addr[31:2],2'b00}.
REQ-016: bus_be  out  4;  bus_wdata  out  32  byte enables, lane-positioned data.
REQ-017: bus_ready  in  1  slave accepts request when bus_req && bus_ready.
REQ-018: bus_rvalid  in  1;  bus_rdata  in  32  read response, any cycle after acceptance.

Function
REQ-019: FSM states: IDLE, REQ, WAIT_R, RESP.
REQ-020: IDLE: legal request = req_store with type != 11, or req_load with a legal func3, and naturally aligned; stall=1 combinationally; capture op, addr, be, wdata; go to REQ.
REQ-021: Misaligned (half with addr[0]=1; word with addr[1:0]!=0) or illegal load func3 (011/110/111): err pulses 1 cycle from IDLE, no bus access, stall=0, stay IDLE.
REQ-022: req_store with type 11: no access, no err, stall=0.
REQ-023: req_load and req_store both high: load wins.
REQ-024: REQ: bus_req=1, address/be/data stable until accepted; store accept -> RESP; load accept -> WAIT_R.
REQ-025: WAIT_R: on bus_rvalid, register the extended result, go to RESP; bus_rvalid in the acceptance cycle is ignored.
REQ-026: RESP: stall=0; rdata_valid=1 for loads only; next state IDLE; no new request accepted in RESP.
REQ-027: Byte lanes: SB be=0001<<addr[1:0], wdata byte replicated to all lanes; SH be=0011<<{addr[1],1'b0}, halfword replicated; SW be=1111.
REQ-028: Load extract: shift bus_rdata right by 8*addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough.
REQ-029: Timeout counter clears on entry to REQ, increments each cycle in REQ/WAIT_R; at TIMEOUT_CYCLES: err pulse, rdata=0, go to RESP (rdata_valid pulses for loads).
REQ-030: Minimum latency: store 2 cycles stalled (IDLE, REQ with bus_ready=1); load 3 cycles stalled plus slave response delay.

Reset
REQ-031: rst low asynchronously forces IDLE; outputs 0: stall, rdata_valid, rdata, err, bus_req, bus_we, bus_be, bus_addr, bus_wdata; counter 0.
REQ-032: Reset mid-transaction abandons it; bus_req drops without waiting for clk; a late bus_rvalid after reset is ignored.

Structure
REQ-033: Shared package riscv_mem_pkg holds load func3 and store type encodings, FSM state typedef, bus width constants.
REQ-034: One combinational sub-module mem_load_align (rdata, offset, func3 -> extended result); the rest is one module.

Verification
REQ-035: SW addr=0x100, wdata=0xDEADBEEF, bus_ready=1 -> bus_be=1111, bus_addr=0x100, stall for 2 cycles, no err.
REQ-036: SB addr=0x103, wdata=0x000000A5 -> bus_be=1000, bus_wdata=0xA5A5A5A5.
REQ-037: LB addr=0x202, bus_rdata=0x12F03456, rvalid 2 cycles later -> rdata=0xFFFFFFF0; LBU same -> 0x000000F0.
REQ-038: LH addr=0x301 -> err pulse, no bus_req, stall=0; LW addr=0x302 -> same.
REQ-039: LW, bus_ready never asserted, TIMEOUT_CYCLES=4 -> err after 4 cycles in REQ, rdata_valid with rdata=0, return to IDLE.
REQ-040: rst low in WAIT_R -> bus_req and stall 0 immediately; rvalid after release produces no rdata_valid.
